// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 3-sample majority vote, parity/stop checking, break
// detection and a show-ahead frame FIFO holding {perr, ferr, data} per entry.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd,
  output logic                          valid,
  output logic [DATA_BITS-1:0]          data,
  output logic                          ferr,
  output logic                          perr,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          brk,
  output logic                          ovf
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_BITS - 1);
  localparam logic             STP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t              state, state_nx;
  logic                rxd_p0, rxd_p1, rxd_prev;
  logic [DIV_W-1:0]    div_cnt;
  logic [OS_W-1:0]     os_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic                stop_cnt;
  logic                smp0, smp1;
  logic [DATA_BITS-1:0] shift;
  logic                perr_r, ferr_r, all_low;
  logic                fall, start_acc, tick, at_s0, at_s1, at_mid, at_end, bit_val;
  logic                push, brk_set;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         cnt;
  logic                full, pop, wr_en;

  // Stage p0/p1: two-flop synchroniser; rxd_prev feeds the falling-edge detector
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_p0   <= rxd;
      rxd_p1   <= rxd_p0;
      rxd_prev <= rxd_p1;
    end
  end

  assign fall      = rxd_prev & ~rxd_p1;
  assign start_acc = (state == S_IDLE) && fall;
  assign tick      = (div_cnt == DIV_LAST);
  assign at_s0     = tick && (os_cnt == OS_S0);
  assign at_s1     = tick && (os_cnt == OS_S1);
  assign at_mid    = tick && (os_cnt == OS_MID);
  assign at_end    = tick && (os_cnt == OS_LAST);
  assign bit_val   = maj3(smp0, smp1, rxd_p1);

  always_ff @(posedge clk) begin
    if (!reset || start_acc) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    brk_set  = 1'b0;
    case (state)
      S_IDLE:  if (fall) state_nx = S_START;
      S_START: begin
        if (at_mid && bit_val) state_nx = S_IDLE;
        else if (at_end)       state_nx = S_DATA;
      end
      S_DATA:  if (at_end && bit_cnt == BIT_LAST) state_nx = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (at_end) state_nx = S_STOP;
      S_STOP:  begin
        // Frame completes mid final stop bit so back-to-back frames are not missed
        if (at_mid && stop_cnt == STP_LAST) begin
          if (shift == '0 && all_low && !bit_val) begin
            state_nx = S_BREAK;
          end else begin
            push     = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rxd_p1) begin
          brk_set  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame datapath: counters and flags are re-armed on every accepted start edge
  always_ff @(posedge clk) begin
    if (at_s0) smp0 <= rxd_p1;
    if (at_s1) smp1 <= rxd_p1;
    if (start_acc) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      all_low  <= 1'b1;
    end else begin
      if (state == S_DATA && at_mid) shift <= {bit_val, shift[DATA_BITS-1:1]};
      if (state == S_DATA && at_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == S_PAR && at_mid)
        perr_r <= bit_val != ((PARITY == 1) ? ~(^shift) : ^shift);
      if (state == S_STOP && at_mid) begin
        if (!bit_val) ferr_r  <= 1'b1;
        else          all_low <= 1'b0;
      end
      if (state == S_STOP && at_end) stop_cnt <= 1'b1;
    end
  end

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign valid = (cnt != '0);
  assign pop   = rd && valid;
  assign wr_en = push && (!full || pop);
  assign count = cnt;
  assign {perr, ferr, data} = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {perr_r, ferr_r | ~bit_val, shift};
  end

  // Stage p2: FIFO pointers and registered event pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      brk    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      cnt <= cnt + 1'b1;
      else if (!wr_en && pop) cnt <= cnt - 1'b1;
      brk <= brk_set;
      ovf <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance on separate lines.
module tb_uart_rx_fifo;

  localparam int BIT = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd_n = 1'b1, rxd_e = 1'b1;
  logic       rd_n = 1'b0, rd_e = 1'b0;
  logic       valid_n, valid_e, ferr_n, ferr_e, perr_n, perr_e;
  logic       brk_n, brk_e, ovf_n, ovf_e;
  logic [7:0] data_n, data_e;
  logic [2:0] count_n, count_e;

  exp_t q_n[$], q_e[$];
  int   checks = 0, errors = 0;
  int   brk_seen = 0, ovf_seen = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_n (
    .clk(clk), .reset(reset), .rxd(rxd_n), .rd(rd_n), .valid(valid_n), .data(data_n),
    .ferr(ferr_n), .perr(perr_n), .count(count_n), .brk(brk_n), .ovf(ovf_n));

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_e (
    .clk(clk), .reset(reset), .rxd(rxd_e), .rd(rd_e), .valid(valid_e), .data(data_e),
    .ferr(ferr_e), .perr(perr_e), .count(count_e), .brk(brk_e), .ovf(ovf_e));

  always @(negedge clk) begin
    if (brk_n) brk_seen++;
    if (ovf_n) ovf_seen++;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit which, input logic v, input int clks);
    if (which) rxd_e = v;
    else       rxd_n = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input bit which, input logic [7:0] b, input bit par_en,
                      input logic par_bit, input logic stop_v, input int gl_bit);
    drive(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == gl_bit) begin
        drive(which, b[i], 85);
        drive(which, ~b[i], 10);
        drive(which, b[i], 65);
      end else begin
        drive(which, b[i], BIT);
      end
    end
    if (par_en) drive(which, par_bit, BIT);
    drive(which, stop_v, BIT);
    drive(which, 1'b1, BIT);
  endtask

  function automatic logic vld_of(input bit which);
    return which ? valid_e : valid_n;
  endfunction

  task automatic pop_check(input bit which, input string tag);
    exp_t e;
    int   n;
    for (n = 0; n < 4000 && !vld_of(which); n++) @(negedge clk);
    chk({tag, "_valid"}, vld_of(which), 1);
    if (which) begin
      if (q_e.size() == 0) begin
        chk({tag, "_queue_empty"}, 1, 0);
        return;
      end
      e = q_e.pop_front();
      chk({tag, "_data"}, data_e, e.d);
      chk({tag, "_ferr"}, ferr_e, e.f);
      chk({tag, "_perr"}, perr_e, e.p);
      rd_e = 1'b1;
      @(negedge clk);
      rd_e = 1'b0;
    end else begin
      if (q_n.size() == 0) begin
        chk({tag, "_queue_empty"}, 1, 0);
        return;
      end
      e = q_n.pop_front();
      chk({tag, "_data"}, data_n, e.d);
      chk({tag, "_ferr"}, ferr_n, e.f);
      chk({tag, "_perr"}, perr_n, e.p);
      rd_n = 1'b1;
      @(negedge clk);
      rd_n = 1'b0;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, o0;
    repeat (5) @(negedge clk);
    chk("rst_valid", valid_n, 0);
    chk("rst_count", count_n, 0);
    chk("rst_data", data_n, 0);
    chk("rst_pulses", {brk_n, ovf_n, brk_e, ovf_e}, 0);
    reset = 1'b1;
    repeat (BIT) @(negedge clk);

    // 8N1 basic frame and pop
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    q_n.push_back('{d: 8'hA5, f: 1'b0, p: 1'b0});
    chk("t1_count", count_n, 1);
    pop_check(1'b0, "t1");
    chk("t1_valid_after_pop", valid_n, 0);
    chk("t1_count_after_pop", count_n, 0);

    // 8E1 parity good/bad
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
    q_e.push_back('{d: 8'h07, f: 1'b0, p: 1'b1});
    pop_check(1'b1, "t2_bad_par");
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    q_e.push_back('{d: 8'h07, f: 1'b0, p: 1'b0});
    pop_check(1'b1, "t2_good_par");
    chk("t2_count_e", count_e, 0);

    // framing error, then break
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    q_n.push_back('{d: 8'h3C, f: 1'b1, p: 1'b0});
    pop_check(1'b0, "t3_ferr");
    b0 = brk_seen;
    drive(1'b0, 1'b0, 20 * BIT);
    chk("t3_brk_before_rise", brk_seen - b0, 0);
    drive(1'b0, 1'b1, 2 * BIT);
    chk("t3_brk_pulses", brk_seen - b0, 1);
    chk("t3_brk_no_push", count_n, 0);

    // overflow: five frames into a 4-deep FIFO
    o0 = ovf_seen;
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, -1);
      if (i <= 4) q_n.push_back('{d: 8'(i), f: 1'b0, p: 1'b0});
      chk("t4_ovf_running", ovf_seen - o0, (i == 5) ? 1 : 0);
    end
    chk("t4_count_full", count_n, 4);
    for (int i = 0; i < 4; i++) pop_check(1'b0, "t4_pop");
    chk("t4_count_empty", count_n, 0);

    // idle-line glitch, then glitch inside bit 3
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 3 * BIT);
    chk("t5_glitch_valid", valid_n, 0);
    chk("t5_glitch_count", count_n, 0);
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
    q_n.push_back('{d: 8'hFF, f: 1'b0, p: 1'b0});
    pop_check(1'b0, "t5_majority");

    // reset mid-frame, FIFO previously holding one entry
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    chk("t6_pre_count", count_n, 1);
    b0 = brk_seen;
    o0 = ovf_seen;
    drive(1'b0, 1'b0, BIT);
    drive(1'b0, 1'b1, BIT);
    drive(1'b0, 1'b0, 2 * BIT);
    reset = 1'b0;
    rxd_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_count", count_n, 0);
    chk("t6_rst_outputs", {valid_n, data_n, ferr_n, perr_n, brk_n, ovf_n}, 0);
    reset = 1'b1;
    q_n.delete();
    repeat (12 * BIT) @(negedge clk);
    chk("t6_no_push_after_rst", count_n, 0);
    chk("t6_no_pulses", (brk_seen - b0) + (ovf_seen - o0), 0);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
    q_n.push_back('{d: 8'h5A, f: 1'b0, p: 1'b0});
    pop_check(1'b0, "t6_clean");
    chk("t6_count_end", count_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
